// File: rtl/pipelined_adder_pkg.sv
// Shared constants for the pipelined adder.
//   DefaultWidth  : default operand/result width in bits
//   DefaultStages : default number of pipeline stages
//   chunk_width() : bits of the carry chain handled by one stage
package pipelined_adder_pkg;

   localparam int unsigned DefaultWidth  = 16;
   localparam int unsigned DefaultStages = 4;

   // Guarded so an illegal STAGES=0 reaches the elaboration check instead of dividing by zero.
   function automatic int unsigned chunk_width(input int unsigned width,
                                               input int unsigned stages);
      return (stages == 0) ? 0 : width / stages;
   endfunction

endpackage

// File: rtl/pipelined_adder_stage.sv
// One slice of the pipelined carry chain.
// Adds chunk IDX of the operands using the carry registered by the previous slice.
// It inserts the result into the running partial sum and registers everything on advance_i.
// The last slice also registers the overflow and zero flags.
//   clk_i, rst_ni : clock, async active-low reset
//   advance_i     : pipeline advance enable
//   valid_i/_o    : operation valid in / registered out
//   a_i/_o, b_i/_o: operands (b already inverted for subtract), skewed alongside the chain
//   sum_i/_o      : partial sum, lower chunks complete
//   carry_i/_o    : carry into / out of this chunk
//   ovf_o, zero_o : signed overflow and zero flags (last slice only, else 0)
module adder_stage
   import pipelined_adder_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth,
   parameter int unsigned CHUNK = chunk_width(DefaultWidth, DefaultStages),
   parameter int unsigned IDX   = 0,
   parameter bit          LAST  = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             advance_i,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [WIDTH-1:0] sum_i,
   input  logic             carry_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_o,
   output logic             ovf_o,
   output logic             zero_o
);

   localparam int unsigned Lo = IDX * CHUNK;

   logic [CHUNK:0]   chunk_res;
   logic [WIDTH-1:0] sum_d, sum_q;
   logic             carry_d, carry_q;
   logic             valid_q;

   always_comb begin
      chunk_res = {1'b0, a_i[Lo +: CHUNK]} + {1'b0, b_i[Lo +: CHUNK]} + {{CHUNK{1'b0}}, carry_i};
      sum_d = sum_i;
      sum_d[Lo +: CHUNK] = chunk_res[CHUNK-1:0];
      carry_d = chunk_res[CHUNK];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         sum_q   <= '0;
         carry_q <= 1'b0;
      end else if (advance_i) begin
         valid_q <= valid_i;
         sum_q   <= sum_d;
         carry_q <= carry_d;
      end
   end

   assign valid_o = valid_q;
   assign sum_o   = sum_q;
   assign carry_o = carry_q;

   if (!LAST) begin : g_skew
      // Upper chunks still need their operands; delay them alongside the chain.
      logic [WIDTH-1:0] a_q, b_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            a_q <= '0;
            b_q <= '0;
         end else if (advance_i) begin
            a_q <= a_i;
            b_q <= b_i;
         end
      end

      assign a_o    = a_q;
      assign b_o    = b_q;
      assign ovf_o  = 1'b0;
      assign zero_o = 1'b0;
   end else begin : g_flags
      logic msb_cin, ovf_d, zero_d;
      logic ovf_q, zero_q;

      always_comb begin
         // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
         msb_cin = a_i[WIDTH-1] ^ b_i[WIDTH-1] ^ sum_d[WIDTH-1];
         ovf_d   = msb_cin ^ carry_d;
         zero_d  = ~|sum_d;
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
         end else if (advance_i) begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
         end
      end

      assign a_o    = '0;
      assign b_o    = '0;
      assign ovf_o  = ovf_q;
      assign zero_o = zero_q;
   end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit with a valid/ready handshake on both sides.
// The carry chain is split into STAGES chunks, LSB first, so each stage adds one chunk.
// The latency is STAGES cycles, and the unit accepts one operation per cycle.
//   clk_in, rst_n_in         : clock, async active-low reset
//   in_valid_in/in_ready_out : input handshake
//   a_in, b_in               : operands
//   carry_in                 : carry-in for add (ignored for subtract)
//   sub_in                   : 0 = A+B+cin, 1 = A-B
//   out_valid_out/out_ready_in : output handshake
//   sum_out, carry_out, overflow_out, zero_out : result and flags
module pipelined_adder
   import pipelined_adder_pkg::*;
#(
   parameter int unsigned WIDTH  = DefaultWidth,
   parameter int unsigned STAGES = DefaultStages
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             in_valid_in,
   output logic             in_ready_out,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             carry_in,
   input  logic             sub_in,
   output logic             out_valid_out,
   input  logic             out_ready_in,
   output logic [WIDTH-1:0] sum_out,
   output logic             carry_out,
   output logic             overflow_out,
   output logic             zero_out
);

   localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);
   localparam int unsigned SDiv  = (STAGES < 1) ? 1 : STAGES;

   if ((WIDTH < 2) || (STAGES < 1) || ((WIDTH % SDiv) != 0)) begin : g_bad_params
      $error("pipelined_adder: need WIDTH >= 2, STAGES >= 1 and WIDTH divisible by STAGES");
   end

   logic                        advance;
   logic [STAGES:0]             valid_w;
   logic [STAGES:0]             carry_w;
   logic [STAGES:0][WIDTH-1:0]  a_w, b_w, sum_w;
   logic [STAGES-1:0]           ovf_w, zero_w;

   // The whole pipeline moves together; it only freezes when a result is waiting downstream.
   assign advance      = out_ready_in || !out_valid_out;
   assign in_ready_out = advance;

   // Subtract is A + ~B + 1, so fold the inversion and forced carry in before stage 0.
   assign valid_w[0] = in_valid_in;
   assign a_w[0]     = a_in;
   assign b_w[0]     = sub_in ? ~b_in : b_in;
   assign carry_w[0] = sub_in | carry_in;
   assign sum_w[0]   = '0;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      adder_stage #(
         .WIDTH (WIDTH),
         .CHUNK (CHUNK),
         .IDX   (k),
         .LAST  (k == STAGES - 1)
      ) u_stage (
         .clk_i     (clk_in),
         .rst_ni    (rst_n_in),
         .advance_i (advance),
         .valid_i   (valid_w[k]),
         .a_i       (a_w[k]),
         .b_i       (b_w[k]),
         .sum_i     (sum_w[k]),
         .carry_i   (carry_w[k]),
         .valid_o   (valid_w[k+1]),
         .a_o       (a_w[k+1]),
         .b_o       (b_w[k+1]),
         .sum_o     (sum_w[k+1]),
         .carry_o   (carry_w[k+1]),
         .ovf_o     (ovf_w[k]),
         .zero_o    (zero_w[k])
      );
   end

   assign out_valid_out = valid_w[STAGES];
   assign sum_out       = sum_w[STAGES];
   assign carry_out     = carry_w[STAGES];
   assign overflow_out  = ovf_w[STAGES-1];
   assign zero_out      = zero_w[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=16, STAGES=4).
module tb_pipelined_adder;

   localparam int W = 16;
   localparam int S = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0] a, b, sum;
   logic         cin, sub, cout, ovf, zero;

   pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
      .clk_in        (clk),
      .rst_n_in      (rst_n),
      .in_valid_in   (in_valid),
      .in_ready_out  (in_ready),
      .a_in          (a),
      .b_in          (b),
      .carry_in      (cin),
      .sub_in        (sub),
      .out_valid_out (out_valid),
      .out_ready_in  (out_ready),
      .sum_out       (sum),
      .carry_out     (cout),
      .overflow_out  (ovf),
      .zero_out      (zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] sum;
      logic         c;
      logic         v;
      logic         z;
      int           cyc;
      bit           lat;
   } exp_t;

   exp_t        sb_q[$];
   int          n_total = 0;
   int          n_bad   = 0;
   int          n_pop   = 0;
   int          cyc     = 0;
   bit          lat_chk = 1'b0;
   bit          rand_mode = 1'b0;
   int          stall_lo = 1;
   int          stall_hi = 0;
   bit          was_stall = 1'b0;
   logic [W+2:0] held;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference: sign-based overflow rule, independent of the carry formulation.
   function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                  input logic ci, input logic sb);
      exp_t         e;
      logic [W-1:0] bb;
      logic [W:0]   full;
      bb     = sb ? ~bv : bv;
      full   = {1'b0, av} + {1'b0, bb} + (sb ? 17'd1 : {16'd0, ci});
      e.sum  = full[W-1:0];
      e.c    = full[W];
      e.v    = (av[W-1] == bb[W-1]) && (full[W-1] != av[W-1]);
      e.z    = (full[W-1:0] == '0);
      e.cyc  = 0;
      e.lat  = 1'b0;
      return e;
   endfunction

   // Monitor: push on accept, pop/compare on output transfer, check holds during stalls.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         sb_q.delete();
         was_stall = 1'b0;
      end else begin
         if (in_valid && in_ready) begin
            e     = model(a, b, cin, sub);
            e.cyc = cyc;
            e.lat = lat_chk;
            sb_q.push_back(e);
         end
         if (out_valid && !out_ready) begin
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            if (was_stall) check("stall_hold", {13'd0, cout, ovf, zero, sum}, {13'd0, held});
            held      = {cout, ovf, zero, sum};
            was_stall = 1'b1;
         end else begin
            was_stall = 1'b0;
            if (out_valid) begin
               if (sb_q.size() == 0) begin
                  check("spurious_out", 32'd1, 32'd0);
               end else begin
                  e = sb_q.pop_front();
                  n_pop++;
                  check("sum", {16'd0, sum}, {16'd0, e.sum});
                  check("carry", {31'd0, cout}, {31'd0, e.c});
                  check("ovf", {31'd0, ovf}, {31'd0, e.v});
                  check("zero", {31'd0, zero}, {31'd0, e.z});
                  if (e.lat) check("latency", cyc - e.cyc, S);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_mode) out_ready = ($urandom_range(0, 9) < 7);
      else           out_ready = !((cyc >= stall_lo) && (cyc <= stall_hi));
   endtask

   task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic ci, input logic sb);
      int   n;
      logic acc;
      a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
      n = 0; acc = 1'b0;
      while (!acc && n < 100) begin
         @(negedge clk);
         acc = in_ready;
         tick();
         n++;
      end
      if (!acc) check("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      int n;
      in_valid = 1'b0;
      n = 0;
      while (sb_q.size() != 0 && n < 80) begin
         tick();
         n++;
      end
      if (sb_q.size() != 0) check("drain_timeout", sb_q.size(), 32'd0);
      tick();
   endtask

   initial begin
      int pop0;
      int n;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_sum", {16'd0, sum}, 32'd0);
      check("rst_flags", {29'd0, cout, ovf, zero}, 32'd0);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      tick();

      // Directed corner cases, one at a time, latency checked.
      lat_chk = 1'b1;
      send(16'hFFFF, 16'h0001, 1'b0, 1'b0); drain();
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0); drain();
      send(16'h0005, 16'h0007, 1'b1, 1'b1); drain();
      send(16'h8000, 16'h0001, 1'b0, 1'b1); drain();
      send(16'h1234, 16'h0FFF, 1'b1, 1'b0); drain();
      send(16'h0000, 16'h0000, 1'b0, 1'b1); drain();

      // Back-to-back with a three-cycle downstream stall.
      lat_chk  = 1'b0;
      pop0     = n_pop;
      stall_lo = cyc + 6;
      stall_hi = cyc + 8;
      for (int i = 0; i < 8; i++)
         send(16'(16'h1111 * (i + 1)), 16'(16'h0F0F + i), i[0], i[1]);
      drain();
      check("stall_count", n_pop - pop0, 32'd8);

      // Mid-flight reset with three operations in the pipe.
      lat_chk = 1'b1;
      send(16'h0102, 16'h0304, 1'b0, 1'b0);
      send(16'hAAAA, 16'h5555, 1'b1, 1'b0);
      send(16'h0F00, 16'h00F0, 1'b0, 1'b1);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      check("reset_setup", {31'd0, out_valid}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_sum", {16'd0, sum}, 32'd0);
      check("midrst_flags", {29'd0, cout, ovf, zero}, 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      #1;
      check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("no_stale", {31'd0, out_valid}, 32'd0);
      end
      send(16'h4000, 16'h4000, 1'b0, 1'b0);
      drain();

      // Random traffic with random backpressure and gaps.
      lat_chk   = 1'b0;
      rand_mode = 1'b1;
      pop0      = n_pop;
      for (int i = 0; i < 40; i++) begin
         int gap;
         gap = $urandom_range(0, 2);
         in_valid = 1'b0;
         repeat (gap) tick();
         send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      end
      rand_mode = 1'b0;
      drain();
      check("rand_count", n_pop - pop0, 32'd40);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
